// File: rtl/contador_decresc_bcd.sv
// Two-digit BCD down-counter (99..00) with preset load, prescaled enable and seven-segment outputs.
// Define CONTADOR_DECRESC_WRAP_EN to reload the latched preset after 00 instead of stopping.
module contador_decresc_bcd #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_units,
   output logic [3:0] q_tens,
   output logic [3:0] q_units,
   output logic       done,
   output logic [6:0] hex1,
   output logic [6:0] hex0
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PsLast = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [3:0]    pre_tens, pre_units;
   logic [3:0]    ld_tens, ld_units;
   logic          q_is_zero, q_is_one;

   assign ld_tens   = (preset_tens  > 4'd9) ? 4'd9 : preset_tens;
   assign ld_units  = (preset_units > 4'd9) ? 4'd9 : preset_units;
   assign q_is_zero = (q_tens == 4'd0) && (q_units == 4'd0);
   assign q_is_one  = (q_tens == 4'd0) && (q_units == 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         q_tens    <= 4'd0;
         q_units   <= 4'd0;
         pre_tens  <= 4'd0;
         pre_units <= 4'd0;
         presc     <= '0;
         done      <= 1'b0;
      end else if (load) begin
         state     <= StIdle;
         q_tens    <= ld_tens;
         q_units   <= ld_units;
         pre_tens  <= ld_tens;
         pre_units <= ld_units;
         presc     <= '0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (en) begin
                  if (q_is_zero) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state <= StRun;
                  end
               end
            end
            StRun: begin
`ifdef CONTADOR_DECRESC_WRAP_EN
               // done is a single-cycle pulse while wrapping
               done <= 1'b0;
`endif
               if (en) begin
                  if (presc == PsLast) begin
                     presc <= '0;
`ifdef CONTADOR_DECRESC_WRAP_EN
                     if (q_is_zero) begin
                        q_tens  <= pre_tens;
                        q_units <= pre_units;
                     end else begin
                        if (q_units != 4'd0) begin
                           q_units <= q_units - 4'd1;
                        end else begin
                           q_units <= 4'd9;
                           q_tens  <= q_tens - 4'd1;
                        end
                        if (q_is_one) done <= 1'b1;
                     end
`else
                     if (q_units != 4'd0) begin
                        q_units <= q_units - 4'd1;
                     end else begin
                        q_units <= 4'd9;
                        q_tens  <= q_tens - 4'd1;
                     end
                     if (q_is_one) begin
                        done  <= 1'b1;
                        state <= StDone;
                     end
`endif
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end
            StDone: begin
            end
            default: state <= StIdle;
         endcase
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   assign hex1 = seg7(q_tens);
   assign hex0 = seg7(q_units);

endmodule

// File: tb/tb_contador_decresc_bcd.sv
// Randomised and directed bench for contador_decresc_bcd against an integer-count reference model.
// Instance 0 uses TICK_DIV=1, instance 1 uses TICK_DIV=3; both share the same stimulus.
module tb_contador_decresc_bcd;

`ifdef CONTADOR_DECRESC_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, load, en;
   logic [3:0] preset_tens, preset_units;
   logic [3:0] qt1, qu1, qt3, qu3;
   logic       d1, d3;
   logic [6:0] h1_1, h0_1, h1_3, h0_3;
   logic [22:0] obs1, obs3;

   int tests_run = 0;
   int fails     = 0;

   int   m_cnt [2];
   int   m_pre [2];
   int   m_ps  [2];
   int   m_st  [2];   // 0 idle, 1 counting, 2 finished
   logic m_done[2];
   int   div_of[2] = '{1, 3};
   logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clk = ~clk;

   contador_decresc_bcd #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .en(en),
      .preset_tens(preset_tens), .preset_units(preset_units),
      .q_tens(qt1), .q_units(qu1), .done(d1), .hex1(h1_1), .hex0(h0_1)
   );

   contador_decresc_bcd #(.TICK_DIV(3)) dut3 (
      .clk(clk), .rst(rst), .load(load), .en(en),
      .preset_tens(preset_tens), .preset_units(preset_units),
      .q_tens(qt3), .q_units(qu3), .done(d3), .hex1(h1_3), .hex0(h0_3)
   );

   assign obs1 = {qt1, qu1, d1, h1_1, h0_1};
   assign obs3 = {qt3, qu3, d3, h1_3, h0_3};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   function automatic int clamp(input logic [3:0] v);
      return (v > 4'd9) ? 9 : int'(v);
   endfunction

   function automatic logic [22:0] exp_vec(input int i);
      int t, u;
      t = m_cnt[i] / 10;
      u = m_cnt[i] % 10;
      return {4'(t), 4'(u), m_done[i], seg_tab[t], seg_tab[u]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_pre[i] = 0; m_ps[i] = 0; m_st[i] = 0; m_done[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (load) begin
            m_cnt[i]  = clamp(preset_tens) * 10 + clamp(preset_units);
            m_pre[i]  = m_cnt[i];
            m_ps[i]   = 0;
            m_done[i] = 1'b0;
            m_st[i]   = 0;
         end else if (m_st[i] == 0) begin
            if (en) begin
               if (m_cnt[i] == 0) begin
                  m_st[i] = 2; m_done[i] = 1'b1;
               end else begin
                  m_st[i] = 1;
               end
            end
         end else if (m_st[i] == 1) begin
            if (WRAP) m_done[i] = 1'b0;
            if (en) begin
               if (m_ps[i] == div_of[i] - 1) begin
                  m_ps[i] = 0;
                  if (WRAP && m_cnt[i] == 0) begin
                     m_cnt[i] = m_pre[i];
                  end else begin
                     m_cnt[i] = m_cnt[i] - 1;
                     if (m_cnt[i] == 0) begin
                        m_done[i] = 1'b1;
                        if (!WRAP) m_st[i] = 2;
                     end
                  end
               end else begin
                  m_ps[i] = m_ps[i] + 1;
               end
            end
         end
      end
   endtask

   // Advance one edge; inputs change only 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; en = 1'b0; preset_tens = 4'd0; preset_units = 4'd0;
      model_reset();
      #1;
      tests_run++;
      if (obs1 !== exp_vec(0) || h1_1 !== 7'h40 || h0_1 !== 7'h40) begin
         fails++;
         $display("FAIL reset_state: got %h required %h", obs1, exp_vec(0));
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      cyc();
      tests_run++;
      if (obs3 !== exp_vec(1)) begin
         fails++;
         $display("FAIL reset_release_div3: got %h required %h", obs3, exp_vec(1));
      end
   endtask

   task automatic test_async_reset();
      load = 1'b1; preset_tens = 4'd4; preset_units = 4'd7; en = 1'b0;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      tests_run++;
      if (qt1 !== 4'd4 || qu1 !== 4'd7) begin
         fails++;
         $display("FAIL pre_reset_47: got %0d%0d required 47", qt1, qu1);
      end
      #3 rst = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if (qt1 !== 4'd0 || qu1 !== 4'd0 || d1 !== 1'b0 || h1_1 !== 7'h40 || h0_1 !== 7'h40) begin
         fails++;
         $display("FAIL async_reset: got q=%0d%0d done=%b hex=%h/%h required 00 0 40/40",
                  qt1, qu1, d1, h1_1, h0_1);
      end
      #1 rst = 1'b0; en = 1'b0;
   endtask

   task automatic test_count_25();
      int  steps;
      bit  saw9;
      load = 1'b1; preset_tens = 4'd2; preset_units = 4'd5; en = 1'b0;
      cyc();
      load = 1'b0;
      tests_run++;
      if (qt1 !== 4'd2 || qu1 !== 4'd5 || d1 !== 1'b0) begin
         fails++;
         $display("FAIL load_25: got %0d%0d done=%b required 25 done=0", qt1, qu1, d1);
      end
      en = 1'b1;
      cyc();
      steps = 0; saw9 = 1'b0;
      for (int c = 0; c < 40 && m_cnt[0] != 0; c++) begin
         cyc();
         steps++;
         tests_run++;
         if (obs1 !== exp_vec(0)) begin
            fails++;
            $display("FAIL count25_step%0d: got %h required %h", steps, obs1, exp_vec(0));
         end
         if (qu1 === 4'd9) saw9 = 1'b1;
      end
      tests_run++;
      if (steps != 25 || d1 !== 1'b1 || qt1 !== 4'd0 || qu1 !== 4'd0 || !saw9) begin
         fails++;
         $display("FAIL count25_done: got steps=%0d done=%b q=%0d%0d saw9=%b required 25 1 00 1",
                  steps, d1, qt1, qu1, saw9);
      end
      en = 1'b0;
   endtask

   task automatic test_clamp_hold();
      load = 1'b1; preset_tens = 4'd12; preset_units = 4'd15; en = 1'b0;
      cyc();
      load = 1'b0;
      tests_run++;
      if (qt1 !== 4'd9 || qu1 !== 4'd9) begin
         fails++;
         $display("FAIL clamp_99: got %0d%0d required 99", qt1, qu1);
      end
      en = 1'b1;
      cyc();
      for (int c = 0; c < 120 && m_cnt[0] != 0; c++) begin
         cyc();
         tests_run++;
         if (obs1 !== exp_vec(0)) begin
            fails++;
            $display("FAIL count99: got %h required %h", obs1, exp_vec(0));
         end
      end
      if (!WRAP) begin
         for (int c = 0; c < 4; c++) begin
            cyc();
            tests_run++;
            if (qt1 !== 4'd0 || qu1 !== 4'd0 || d1 !== 1'b1) begin
               fails++;
               $display("FAIL done_hold: got q=%0d%0d done=%b required 00 1", qt1, qu1, d1);
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_prescale();
      load = 1'b1; preset_tens = 4'd0; preset_units = 4'd3; en = 1'b0;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      cyc(); cyc();
      tests_run++;
      if (qu3 !== 4'd3) begin
         fails++;
         $display("FAIL presc_early: got %0d required 3", qu3);
      end
      en = 1'b0;
      cyc(); cyc();
      tests_run++;
      if (qu3 !== 4'd3) begin
         fails++;
         $display("FAIL presc_pause: got %0d required 3", qu3);
      end
      en = 1'b1;
      cyc();
      tests_run++;
      if (qu3 !== 4'd2 || obs3 !== exp_vec(1)) begin
         fails++;
         $display("FAIL presc_phase: got %h required %h", obs3, exp_vec(1));
      end
      for (int c = 0; c < 9; c++) begin
         cyc();
         tests_run++;
         if (obs3 !== exp_vec(1)) begin
            fails++;
            $display("FAIL presc_run%0d: got %h required %h", c, obs3, exp_vec(1));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_zero_load();
      load = 1'b1; preset_tens = 4'd0; preset_units = 4'd0; en = 1'b0;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      tests_run++;
      if (d1 !== 1'b1 || qu1 !== 4'd0 || d3 !== 1'b1) begin
         fails++;
         $display("FAIL zero_to_done: got done=%b/%b q=%0d required 1/1 0", d1, d3, qu1);
      end
      load = 1'b1; preset_units = 4'd5;
      cyc();
      tests_run++;
      if (qu1 !== 4'd5 || d1 !== 1'b0) begin
         fails++;
         $display("FAIL load_with_en: got q=%0d done=%b required 5 0", qu1, d1);
      end
      load = 1'b0; en = 1'b0;
      cyc();
      en = 1'b1;
      cyc(); cyc();
      tests_run++;
      if (qu1 !== 4'd4 || obs1 !== exp_vec(0)) begin
         fails++;
         $display("FAIL idle_then_count: got %h required %h", obs1, exp_vec(0));
      end
      en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [3:0] wq[6] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
      logic       wd[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      load = 1'b1; preset_tens = 4'd0; preset_units = 4'd2; en = 1'b0;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      for (int c = 0; c < 6; c++) begin
         cyc();
         tests_run++;
         if (qu1 !== wq[c] || qt1 !== 4'd0 || d1 !== wd[c]) begin
            fails++;
            $display("FAIL wrap_step%0d: got q=%0d%0d done=%b required 0%0d %b",
                     c, qt1, qu1, d1, wq[c], wd[c]);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         load         = ($urandom_range(0, 19) == 0);
         en           = ($urandom_range(0, 3) != 0);
         preset_tens  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 1));
         preset_units = 4'($urandom_range(0, 15));
         cyc();
         tests_run++;
         if (obs1 !== exp_vec(0) || obs3 !== exp_vec(1)) begin
            fails++;
            $display("FAIL random%0d: got %h/%h required %h/%h",
                     c, obs1, obs3, exp_vec(0), exp_vec(1));
         end
         if ($urandom_range(0, 59) == 0) begin
            #2 rst = 1'b1;
            #1 model_reset();
            tests_run++;
            if (obs1 !== exp_vec(0) || obs3 !== exp_vec(1)) begin
               fails++;
               $display("FAIL random_rst%0d: got %h/%h required %h/%h",
                        c, obs1, obs3, exp_vec(0), exp_vec(1));
            end
            #1 rst = 1'b0;
         end
      end
      load = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_count_25();
      test_clamp_hold();
      test_prescale();
      test_zero_load();
      if (WRAP) test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/contador_decresc_bcd.md
# contador_decresc_bcd

Two-digit BCD down-counter (99..00) with synchronous preset load, count enable, a prescaler and a completion flag. It drives two active-low seven-segment digits. It is the counting-down counterpart of the lab's up-counter/BCD-decoder chain. It sits between board switches/keys and the HEX displays, and serves as a countdown timer for later lab exercises.

## Interface
- `TICK_DIV`, default 1 — clock cycles per count step; must be ≥1; prescaler width is `$clog2(TICK_DIV)`, minimum 1 bit.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — reset, asynchronous and active-high.
- `load` input 1 — synchronous preset load, highest priority after `rst`.
- `en` input 1 — count enable (level).
- `preset_tens` input 4 — BCD tens preset; values >9 clamp to 9.
- `preset_units` input 4 — BCD units preset; values >9 clamp to 9.
- `q_tens` output 4 — current tens digit, BCD.
- `q_units` output 4 — current units digit, BCD.
- `done` output 1 — count reached 00.
- `hex1` output 7 — tens digit segments, active-low, bit0=a … bit6=g.
- `hex0` output 7 — units digit segments, same encoding.

## Operation
- State machine states:
  - **IDLE**: holds the count and waits.
  - **RUN**: counting.
  - **DONE**: the count has reached 00.
- Reset: state=IDLE, q=00, the latched preset=00, prescaler=0, done=0. Hex outputs then show "00" (0x40, 0x40).
- Priority: `rst` > `load` > counting.
- `load`=1 in any state: q ← clamped preset; the clamped preset is also latched; prescaler ← 0; done ← 0; state ← IDLE.
- **IDLE**: if `en`=1 and q≠00, go to RUN. If `en`=1 and q=00, go to DONE with done←1. Otherwise hold.
- **RUN**:
  - With `en`=1 the prescaler advances; when it is at TICK_DIV-1 a tick occurs and the prescaler returns to 0.
  - With `en`=0 both the prescaler and q hold (pause); the state stays RUN.
  - On each tick q decrements in BCD: units>0 gives units-1; units=0 gives units←9 and tens-1.
  - A tick with q=01 gives q←00, done←1, state←DONE, all on the same edge.
- **DONE**: q holds 00 and done holds 1. `en` is ignored; only `load` or `rst` leaves DONE.
- Segment decode is combinational from q:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - A non-BCD q is unreachable; decode it as blank (0x7F).

## Timing
- All of q, done, state and prescaler are registered; hex outputs are combinational from q with zero added latency.
- `rst` asserted mid-count clears everything immediately, independent of `clk`. Release is followed by IDLE on the next edge.
- A load at edge k makes q valid after edge k.
- With TICK_DIV=1: `en` high at edge k in IDLE gives RUN after k, and the first decrement at edge k+1. Steps then follow every cycle.
- With TICK_DIV=N: steps occur every N enabled cycles. Pausing with `en` low preserves the partial prescaler count.
- From a preset P (nonzero, TICK_DIV=1, `en` held high), done rises at edge k+P (with k the IDLE→RUN edge as above).
- `load` together with `en` on the same edge: the load wins and the state is IDLE. Counting starts from the next edge.

## Configuration
- `CONTADOR_DECRESC_WRAP_EN` defined:
  - A tick in RUN with q=01 sets q←00 and pulses done for exactly one cycle; the state stays RUN.
  - The next tick reloads the latched preset and counting continues.
  - DONE is entered only from IDLE with q=00.
- `CONTADOR_DECRESC_WRAP_EN` undefined: the stop-at-00 behaviour above applies, with done level-held in DONE.

## Test plan
- Reset mid-count (q=47 in RUN), assert `rst` between edges: q=00, done=0, hex1=hex0=0x40 immediately, without waiting for a clock edge.
- Load 25, `en`=1, TICK_DIV=1: q sequence 25,24,…,20,19,…,01,00. done rises on the same edge that q becomes 00; hex0 shows 0x10 when units=9.
- Load preset_tens=12, preset_units=15: q=99. `en` held in DONE after counting completes: q remains 00 and done remains 1.
- TICK_DIV=3, load 03, drop `en` for 2 cycles mid-step: each step takes exactly 3 enabled cycles, and the pause does not lose the prescaler phase.
- Load 00, `en`=1: the state goes IDLE→DONE in one cycle and done=1. `load` of 05 with `en`=1 on the same edge: q=05 in IDLE with done=0.
- With `CONTADOR_DECRESC_WRAP_EN`, load 02, TICK_DIV=1: q runs 02,01,00,02,01,00. done is high for exactly one cycle per 00.
